// File: rtl/single_port_blockram_arbiter_if.sv
// -----------------------------------------------------------------------------
// single_port_blockram_arbiter_if
//
// Bundles the requester-side handshake and response bus of the shared
// blockram arbiter. All vectors are packed by requester, so requester i owns
// bit i of the 1-bit-per-requester vectors and slice i of the address/data
// vectors.
//
//   request_valid_in    requester -> arbiter  per-requester request valid
//   request_write_in    requester -> arbiter  1 = write, 0 = read
//   request_addr_in     requester -> arbiter  packed set addresses
//   request_data_in     requester -> arbiter  packed write elements
//   request_ready_out   arbiter -> requester  one-hot grant (0 or 1 bits set)
//   response_valid_out  arbiter -> requester  one-hot read-response valid
//   response_data_out   arbiter -> requester  shared read data bus
//
// Modports:
//   master : requester side (drives requests, observes grants/responses)
//   slave  : arbiter side   (observes requests, drives grants/responses)
// -----------------------------------------------------------------------------
interface single_port_blockram_arbiter_if #(
   parameter int NUMBER_REQUESTERS           = 4,
   parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
   parameter int SET_PTR_WIDTH_IN_BITS       = 6
);

   logic [NUMBER_REQUESTERS-1:0]                             request_valid_in;
   logic [NUMBER_REQUESTERS-1:0]                             request_write_in;
   logic [NUMBER_REQUESTERS*SET_PTR_WIDTH_IN_BITS-1:0]       request_addr_in;
   logic [NUMBER_REQUESTERS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_data_in;
   logic [NUMBER_REQUESTERS-1:0]                             request_ready_out;
   logic [NUMBER_REQUESTERS-1:0]                             response_valid_out;
   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]                   response_data_out;

   modport master (
      output request_valid_in,
      output request_write_in,
      output request_addr_in,
      output request_data_in,
      input  request_ready_out,
      input  response_valid_out,
      input  response_data_out
   );

   modport slave (
      input  request_valid_in,
      input  request_write_in,
      input  request_addr_in,
      input  request_data_in,
      output request_ready_out,
      output response_valid_out,
      output response_data_out
   );

endinterface

// File: rtl/single_port_blockram_arbiter.sv
// -----------------------------------------------------------------------------
// single_port_blockram
//
// Single-port synchronous RAM. One access per cycle when access_en_in is high:
// a write stores write_element_in, a read registers the addressed element onto
// read_element_out on the same edge (one-cycle read latency). The read
// register holds its value during writes and idle cycles.
//
//   clk_in              in   clock, rising edge
//   access_en_in        in   perform an access this cycle
//   write_en_in         in   1 = write, 0 = read (qualified by access_en_in)
//   access_set_addr_in  in   set address
//   write_element_in    in   element to write
//   read_element_out    out  registered read data
// -----------------------------------------------------------------------------
module single_port_blockram #(
   parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
   parameter int NUMBER_SETS                 = 64,
   parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
   input  logic                                   clk_in,
   input  logic                                   access_en_in,
   input  logic                                   write_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_in,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out
);

   logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem [NUMBER_SETS];

   // NOTE: the storage array and its read register carry no reset so the
   // array maps onto block RAM; their contents are undefined until written.
   always_ff @(posedge clk_in) begin
      if (access_en_in) begin
         if (write_en_in) begin
            mem[access_set_addr_in] <= write_element_in;
         end else begin
            read_element_out <= mem[access_set_addr_in];
         end
      end
   end

endmodule

// -----------------------------------------------------------------------------
// single_port_blockram_arbiter
//
// Shares one single_port_blockram between NUMBER_REQUESTERS requesters. A
// combinational round-robin arbiter grants at most one valid request per
// cycle, starting its scan at priority_ptr. The granted request is registered
// into an issue stage that drives the RAM directly; reads then pass through a
// one-entry response stage that flags the owning requester while the RAM read
// register presents the data. Handshake to response is two cycles, writes
// produce no response, and one request is accepted every cycle.
//
//   clk_in     in   clock, rising edge
//   reset_in   in   asynchronous active-low reset; also forces grants low
//   bus        slave modport of single_port_blockram_arbiter_if
// -----------------------------------------------------------------------------
module single_port_blockram_arbiter #(
   parameter int NUMBER_REQUESTERS           = 4,
   parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
   parameter int NUMBER_SETS                 = 64,
   parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
   input  logic                           clk_in,
   input  logic                           reset_in,
   single_port_blockram_arbiter_if.slave  bus
);

   localparam int N      = NUMBER_REQUESTERS;
   localparam int DW     = SINGLE_ELEMENT_SIZE_IN_BITS;
   localparam int AW     = SET_PTR_WIDTH_IN_BITS;
   localparam int ID_W   = $clog2(N);

   localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(N);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

   // Arbitration
   logic [ID_W-1:0] priority_ptr;
   logic            grant_found;
   logic [ID_W-1:0] grant_id;
   logic [ID_W:0]   scan_sum;
   logic [ID_W-1:0] scan_id;

   // Granted request fields
   logic            sel_write;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // Issue stage
   logic            issue_valid;
   logic            issue_write;
   logic [AW-1:0]   issue_addr;
   logic [DW-1:0]   issue_data;
   logic [ID_W-1:0] issue_id;

   // Response stage
   logic            resp_valid;
   logic [ID_W-1:0] resp_id;

   logic [N-1:0]    ready_vec;
   logic [N-1:0]    resp_onehot;
   logic [DW-1:0]   ram_read_element;

   // Round-robin scan: visit ptr, ptr+1, ... wrapping modulo N, and take the
   // first valid requester. The extra sum bit lets the wrap work for any N.
   // NOTE: every variable written in this block gets a default first, so no
   // path can leave one unassigned and infer a latch.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_sum    = '0;
      scan_id     = '0;
      for (int k = 0; k < N; k++) begin
         scan_sum = {1'b0, priority_ptr} + (ID_W+1)'(k);
         if (scan_sum >= N_EXT) begin
            scan_sum = scan_sum - N_EXT;
         end
         scan_id = scan_sum[ID_W-1:0];
         if (!grant_found && bus.request_valid_in[scan_id]) begin
            grant_found = 1'b1;
            grant_id    = scan_id;
         end
      end
   end

   // Pull the granted requester's fields out of the packed buses.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_write = bus.request_write_in[i];
            sel_addr  = bus.request_addr_in[i*AW +: AW];
            sel_data  = bus.request_data_in[i*DW +: DW];
         end
      end
   end

   // Ready is the one-hot grant, held low while reset is asserted so no
   // requester believes it was served during reset.
   always_comb begin
      ready_vec = '0;
      if (grant_found && reset_in) begin
         ready_vec[grant_id] = 1'b1;
      end
   end

   assign bus.request_ready_out = ready_vec;

   // Pointer moves just past the winner; holds when nobody is granted.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         priority_ptr <= '0;
      end else if (grant_found) begin
         priority_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
   end

   // Issue stage: loaded every edge, valid only for an actual handshake.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         issue_valid <= 1'b0;
         issue_write <= 1'b0;
         issue_addr  <= '0;
         issue_data  <= '0;
         issue_id    <= '0;
      end else begin
         issue_valid <= grant_found;
         issue_write <= sel_write;
         issue_addr  <= sel_addr;
         issue_data  <= sel_data;
         issue_id    <= grant_id;
      end
   end

   // Response stage tracks issued reads alongside the RAM read register.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
      end else begin
         resp_valid <= issue_valid & ~issue_write;
         resp_id    <= issue_id;
      end
   end

   always_comb begin
      resp_onehot = '0;
      if (resp_valid) begin
         resp_onehot[resp_id] = 1'b1;
      end
   end

   assign bus.response_valid_out = resp_onehot;
   assign bus.response_data_out  = ram_read_element;

   single_port_blockram #(
      .SINGLE_ELEMENT_SIZE_IN_BITS (DW),
      .NUMBER_SETS                 (NUMBER_SETS),
      .SET_PTR_WIDTH_IN_BITS       (AW)
   ) u_ram (
      .clk_in             (clk_in),
      .access_en_in       (issue_valid),
      .write_en_in        (issue_valid & issue_write),
      .access_set_addr_in (issue_addr),
      .write_element_in   (issue_data),
      .read_element_out   (ram_read_element)
   );

endmodule

// File: tb/tb_single_port_blockram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_single_port_blockram_arbiter
//
// Directed bench for single_port_blockram_arbiter with four requesters,
// 64-bit elements and 64 sets. A reference model tracks the round-robin
// pointer and the RAM contents; every read handshake pushes its expected
// response onto a scoreboard queue, popped when its response cycle comes up.
// -----------------------------------------------------------------------------
module tb_single_port_blockram_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int AW = 6;

   typedef struct {
      int          id;
      logic [63:0] data;
      int          due;
   } resp_t;

   logic clk;
   logic rst_n;

   single_port_blockram_arbiter_if #(
      .NUMBER_REQUESTERS           (N),
      .SINGLE_ELEMENT_SIZE_IN_BITS (DW),
      .SET_PTR_WIDTH_IN_BITS       (AW)
   ) bus ();

   single_port_blockram_arbiter #(
      .NUMBER_REQUESTERS           (N),
      .SINGLE_ELEMENT_SIZE_IN_BITS (DW),
      .NUMBER_SETS                 (64),
      .SET_PTR_WIDTH_IN_BITS       (AW)
   ) dut (
      .clk_in   (clk),
      .reset_in (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] mem_m [64];
   int          ptr_m;
   resp_t       sb [$];
   int          cycle_n;
   bit          pend_valid;
   logic [5:0]  pend_addr;
   logic [63:0] pend_old;

   int pass_cnt;
   int fail_cnt;
   int total_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit w, input logic [5:0] a,
                          input logic [63:0] d);
      bus.request_valid_in[i]          = v;
      bus.request_write_in[i]          = w;
      bus.request_addr_in[i*AW +: AW]  = a;
      bus.request_data_in[i*DW +: DW]  = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 6'd0, 64'd0);
   endtask

   // One clock cycle: at the falling edge check the grant and response
   // against the model, update the model for the coming handshake, then
   // advance past the rising edge. exp_grant >= 0 adds a directed grant check.
   task automatic step(input int exp_grant, output int g);
      logic [3:0]  exp_rdy;
      logic [5:0]  a;
      logic [63:0] d;
      resp_t       e;
      int          idx;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (ptr_m + k) % N;
         if (g < 0 && bus.request_valid_in[idx]) g = idx;
      end
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("ready", 64'(bus.request_ready_out), 64'(exp_rdy));
      if (exp_grant >= 0)
         check("directed_grant", 64'(bus.request_ready_out), 64'(4'b0001 << exp_grant));
      if (sb.size() > 0 && sb[0].due == cycle_n) begin
         e = sb.pop_front();
         check("resp_valid", 64'(bus.response_valid_out), 64'(4'b0001 << e.id));
         check("resp_data", bus.response_data_out, e.data);
      end else begin
         check("resp_idle", 64'(bus.response_valid_out), 64'd0);
      end
      pend_valid = 1'b0;
      if (g >= 0) begin
         ptr_m = (g + 1) % N;
         a = bus.request_addr_in[g*AW +: AW];
         d = bus.request_data_in[g*DW +: DW];
         if (bus.request_write_in[g]) begin
            pend_valid = 1'b1;
            pend_addr  = a;
            pend_old   = mem_m[a];
            mem_m[a]   = d;
         end else begin
            sb.push_back('{id: g, data: mem_m[a], due: cycle_n + 2});
         end
      end
      @(posedge clk);
      cycle_n++;
      #1;
   endtask

   task automatic drain();
      int g;
      clear_all();
      for (int k = 0; k < 4; k++) step(-1, g);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int g;
      pass_cnt   = 0;
      fail_cnt   = 0;
      total_cnt  = 0;
      ptr_m      = 0;
      cycle_n    = 0;
      pend_valid = 1'b0;

      // Reset held with every requester valid (writes preloading 0x10..0x13).
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 6'(i), 64'h10 + 64'(i));
      repeat (2) begin
         @(negedge clk);
         check("reset_ready", 64'(bus.request_ready_out), 64'd0);
         check("reset_resp", 64'(bus.response_valid_out), 64'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First grant after release goes to requester 0; drop each winner.
      for (int i = 0; i < N; i++) begin
         step(i, g);
         if (g >= 0) set_req(g, 1'b0, 1'b0, 6'd0, 64'd0);
      end
      drain();

      // Basic write then read by requester 1 on address 63.
      set_req(1, 1'b1, 1'b1, 6'd63, 64'hFFFFFFFF00000000);
      step(1, g);
      set_req(1, 1'b1, 1'b0, 6'd63, 64'd0);
      step(1, g);
      drain();

      // Leave the pointer at 0, then all four read addresses 0..3.
      set_req(3, 1'b1, 1'b0, 6'd3, 64'd0);
      step(3, g);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 6'(i), 64'd0);
      for (int i = 0; i < 8; i++) step(i % N, g);
      drain();

      // Pointer skip/wrap: grant 2 leaves ptr at 3, then only 0 and 2 valid.
      set_req(2, 1'b1, 1'b0, 6'd2, 64'd0);
      step(2, g);
      set_req(0, 1'b1, 1'b0, 6'd0, 64'd0);
      step(0, g);
      step(2, g);
      drain();

      // A write produces no response; a later read returns the written value.
      set_req(3, 1'b1, 1'b1, 6'd5, 64'h00000000FFFFFFFF);
      step(3, g);
      drain();
      set_req(0, 1'b1, 1'b0, 6'd5, 64'd0);
      step(0, g);
      drain();

      // Reset mid-flight: read by 0, then write by 1 to address 0; reset lands
      // while the read sits in the response stage and the write in issue.
      set_req(0, 1'b1, 1'b0, 6'd63, 64'd0);
      step(0, g);
      clear_all();
      set_req(1, 1'b1, 1'b1, 6'd0, 64'hDEADBEEFCAFEF00D);
      step(1, g);
      rst_n = 1'b0;
      #1;
      check("midflight_reset_ready", 64'(bus.request_ready_out), 64'd0);
      check("midflight_reset_resp", 64'(bus.response_valid_out), 64'd0);
      sb.delete();
      if (pend_valid) mem_m[pend_addr] = pend_old;
      pend_valid = 1'b0;
      ptr_m = 0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 6'(i), 64'd0);
      step(0, g);
      clear_all();
      step(-1, g);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/single_port_blockram_arbiter.md
# single_port_blockram_arbiter

Shares one `single_port_blockram` instance between `NUMBER_REQUESTERS` independent requesters. Each requester issues single-element reads or writes through a valid/ready handshake, and a round-robin arbiter grants at most one request per cycle. The granted request is registered into an issue stage that drives the RAM. Read data is returned on a shared data bus, tagged with a one-hot response valid. The block sits between cache/queue logic and the blockram and is the only master of the RAM it instantiates.

## Interface
- `NUMBER_REQUESTERS`, 4: number of requester ports (≥2).
- `SINGLE_ELEMENT_SIZE_IN_BITS`, 64: element width, passed to the RAM.
- `NUMBER_SETS`, 64: RAM depth.
- `SET_PTR_WIDTH_IN_BITS`, `$clog2(NUMBER_SETS)`: address width.
- `clk_in`  in  1  single clock; everything samples on the rising edge.
- `reset_in`  in  1  asynchronous, active-low reset.
- `request_valid_in`  in  NUMBER_REQUESTERS  per-requester request valid.
- `request_write_in`  in  NUMBER_REQUESTERS  1 = write, 0 = read.
- `request_addr_in`  in  NUMBER_REQUESTERS×SET_PTR_WIDTH_IN_BITS  packed; requester i occupies slice i.
- `request_data_in`  in  NUMBER_REQUESTERS×SINGLE_ELEMENT_SIZE_IN_BITS  packed write data.
- `request_ready_out`  out  NUMBER_REQUESTERS  one-hot grant; 0 or 1 bits set.
- `response_valid_out`  out  NUMBER_REQUESTERS  one-hot read-response valid.
- `response_data_out`  out  SINGLE_ELEMENT_SIZE_IN_BITS  read data for the flagged requester.

## Operation
- **Arbitration** is combinational. `request_ready_out[i]`=1 for the first i with `request_valid_in[i]`=1, scanning upward from `priority_ptr` and wrapping modulo N. It is all-zero when no valid is set.
- **Handshake** completes at a rising edge where valid[i] and ready[i] are both 1.
- **Ready** never depends on `request_ready_out` of another cycle. There is no backpressure from the RAM; the block accepts one request every cycle.
- **Priority pointer**
  - On a handshake by requester g, `priority_ptr` ← (g+1) mod N.
  - With no handshake, the pointer holds.
  - At N=4 the pointer wraps from 3 to 0.
- **Issue stage registers:** `issue_valid`, `issue_write`, `issue_addr`, `issue_data`, `issue_id`. These are loaded on every edge. `issue_valid` equals the handshake of that edge.
- **RAM drive from the issue stage:**
  - `access_en_in`=`issue_valid`
  - `write_en_in`=`issue_valid & issue_write`
  - `access_set_addr_in`=`issue_addr`
  - `write_element_in`=`issue_data`
- **Response stage registers:** `resp_valid`, `resp_id`. They load `issue_valid & ~issue_write` and `issue_id`.
- **Response outputs:**
  - `response_valid_out` = `resp_valid` ? one-hot(`resp_id`) : 0.
  - `response_data_out` = RAM `read_element_out`, passed through.
- **Writes** produce no response.
- **Ordering:** requests execute in handshake order. A read issued the cycle after a write to the same address returns the new data.
- **Unused outputs:** when `resp_valid`=0, `response_data_out` content is don't-care.

## Timing
- **Reset values** (while `reset_in`=0, asynchronously):
  - `priority_ptr`=0
  - all issue/response registers 0
  - `request_ready_out`=0 (forced low during reset)
  - `response_valid_out`=0
  - RAM `access_en_in`=0
- **Read latency:** a handshake at edge E0 → RAM access at edge E1 → `response_valid_out` high during the cycle after E1, for exactly one cycle. This is 2 cycles from handshake to response.
- **Throughput:** one request per cycle. Back-to-back reads yield back-to-back responses in grant order.
- **Write completion:** a write handshaken at E0 is committed to the RAM at E1.
- **Simultaneous requests:** all N requesters valid every cycle → grants rotate p, p+1, …, each requester served once per N cycles.
- **Single requester:** one requester continuously valid → granted every cycle.
- **Reset mid-operation:** asserting reset drops in-flight issue/response entries.
  - No `response_valid_out` is produced for them.
  - An issued write not yet past E1 is not committed.
  - After release, the first grant starts from requester 0.
- **Validity:** a request whose valid drops before the handshake is simply not served. Valid is not required to be sticky.

## Test plan
- **Reset:** hold `reset_in`=0 with all valids=1 → `request_ready_out`=0 and `response_valid_out`=0. Release → first grant goes to requester 0.
- **Basic write-read:** requester 1 writes 0xFFFFFFFF00000000 to addr 63, then reads addr 63 the next cycle → `response_valid_out`=4'b0010 exactly 2 cycles after the read handshake, with data 0xFFFFFFFF00000000.
- **Round-robin fairness:** all 4 valid as reads to addrs 0..3, preloaded with 0x10..0x13, for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Responses arrive in the same order with matching data.
- **Pointer skip/wrap:** ptr=3 (after a grant to 2), only requesters 0 and 2 valid → grant 0. Next cycle, same valids → grant 2.
- **Write has no response:** requester 3 writes 0x00000000FFFFFFFF to addr 5 → `response_valid_out` stays 0. Requester 0 reads addr 5 → returns 0x00000000FFFFFFFF.
- **Reset mid-flight:** pulse reset low for half a cycle, one cycle after a read handshake → no response appears. A write caught in the issue stage is absent on a later read, which returns the old value.
